sync_word_capture: RTL and testbench
====================================

// Module: sync_word_capture
// PURPOSE
//  Sits directly downstream of the strobe synchronizer. It consumes the outclk-domain
//  synced strobe that marks "source word ready" from a foreign clock domain.
//  It converts the strobe to a single-cycle event, waits for the quasi-static bus to settle,
//  and double-samples the bus. Matching samples are pushed into a small FWFT FIFO with a
//  valid/ready interface toward the RC4 control FSM.
//  It also flags dropped or inconsistent words and counts every event.
// PARAMETERS
//  DATA_W        24  width of captured word (RC4 secret key)
//  SETTLE_CYCLES 2   outclk cycles waited after event before first sample; legal range >=1
//  FIFO_DEPTH    4   output FIFO entries; power of 2, >=2
//  CNT_W         8   width of event_count
// PORTS
//  outclk       in   1       clock
//  reset        in   1       reset; asynchronous, active-high
//  sync_strobe  in   1       synced strobe from synchronizer stage (may be high >1 cycle)
//  async_data   in   DATA_W  source-domain bus, held stable by source protocol
//  out_ready    in   1       consumer accepts head word
//  clear_flags  in   1       clears sticky overflow/mismatch
//  out_valid    out  1       FIFO non-empty
//  out_data     out  DATA_W  FIFO head (FWFT); 0 when empty
//  overflow     out  1       sticky: word or event dropped
//  mismatch     out  1       sticky: double-sample disagreed
//  event_count  out  CNT_W   total strobe events, wraps mod 2^CNT_W
//  busy         out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, FIFO empty, out_valid=0, out_data=0, overflow=0,
//   mismatch=0, event_count=0, busy=0, strobe_d=1.
//  - strobe_d=1 at reset means a strobe held high through reset gives no event.
//  Event: sync_strobe & ~strobe_d; strobe_d <= sync_strobe every cycle. One event per rising edge.
//  event_count increments on every event, in any state.
//  FSM (the event cycle = cycle 0):
//   IDLE     : on event -> SETTLE, load settle counter with SETTLE_CYCLES.
//   SETTLE   : decrement each cycle; leave after SETTLE_CYCLES cycles (cycles 1..S) -> SAMPLE_A.
//   SAMPLE_A : samp_a <= async_data -> SAMPLE_B.
//   SAMPLE_B : samp_b <= async_data -> CHECK.
//   CHECK    : if samp_a==samp_b -> push samp_a; else set mismatch, drop word. Then -> IDLE.
//  Latency: push at end of cycle S+3; out_valid=1 from cycle S+4 if FIFO was empty.
//   With S=2 that is cycle 6.
//  Event while busy: ignored for capture, sets overflow, still counted.
//  FIFO push in CHECK:
//   - accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle;
//   - otherwise word dropped and overflow set.
//  Pop: out_valid & out_ready. Pop on empty is a no-op.
//  Simultaneous push+pop: count unchanged, ordering preserved.
//  Pointers wrap mod FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
//  clear_flags clears overflow/mismatch next cycle; a set in the same cycle wins over clear.
//  Reset mid-operation aborts capture, discards FIFO contents, returns all outputs to reset values.
// TESTING
//  1 Strobe 0->1 held 2 cycles, data=24'h0A1B2C stable, S=2
//    -> one event, out_valid rises at cycle 6, out_data=24'h0A1B2C, event_count=1.
//  2 Data changes 24'h000001->24'h000002 between SAMPLE_A and SAMPLE_B
//    -> no push, mismatch=1, out_valid stays 0.
//  3 Five words with out_ready=0, DEPTH=4
//    -> 4 stored in order, 5th dropped, overflow=1.
//    -> then out_ready=1 drains in order, and out_data=0 once empty.
//  4 Second strobe edge arrives during SETTLE
//    -> ignored, overflow=1, event_count=2, exactly one word pushed.
//  5 FIFO full, push and pop in same cycle
//    -> push accepted, count stays 4, overflow stays 0.
//    -> clear_flags pulse then clears prior flags.
//  6 Assert reset in SAMPLE_B with 2 words queued; sync_strobe held high across reset release
//    -> all outputs 0, no event after release until strobe falls and rises again.

Source files
------------

// File: rtl/sync_word_capture.sv
// rtl/sync_word_capture.sv - turns a synced strobe into a settled, double-sampled word pushed into a small FWFT FIFO
module sync_word_capture #(
  parameter int DATA_W        = 24,
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_W         = 8
) (
  input  logic              outclk,
  input  logic              reset,
  input  logic              sync_strobe,
  input  logic [DATA_W-1:0] async_data,
  input  logic              out_ready,
  input  logic              clear_flags,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              overflow,
  output logic              mismatch,
  output logic [CNT_W-1:0]  event_count,
  output logic              busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE_A, SAMPLE_B, CHECK} state_t;

  state_t            state, state_nxt;
  logic              strobe_d;
  logic              evt;
  logic [SW-1:0]     settle_cnt;
  logic [DATA_W-1:0] samp_a, samp_b;
  logic              settle_load, samp_a_en, samp_b_en, check_en;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push_req, push_ok, pop;
  logic              overflow_set, mismatch_set;

  // strobe_d resets high so a strobe held through reset is not an edge
  assign evt = sync_strobe & ~strobe_d;

  always_ff @(posedge outclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (evt) state_nxt = SETTLE;
      SETTLE:   if (settle_cnt == SW'(1)) state_nxt = SAMPLE_A;
      SAMPLE_A: state_nxt = SAMPLE_B;
      SAMPLE_B: state_nxt = CHECK;
      CHECK:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    settle_load = (state == IDLE) & evt;
    samp_a_en   = (state == SAMPLE_A);
    samp_b_en   = (state == SAMPLE_B);
    check_en    = (state == CHECK);
  end

  assign out_valid    = (count != '0);
  assign out_data     = out_valid ? mem[rd_ptr] : '0;
  assign pop          = out_valid & out_ready;
  assign push_req     = check_en & (samp_a == samp_b);
  // a full FIFO still takes the word when the head leaves in the same cycle
  assign push_ok      = push_req & ((count < CW'(FIFO_DEPTH)) | pop);
  assign overflow_set = (evt & busy) | (push_req & ~push_ok);
  assign mismatch_set = check_en & (samp_a != samp_b);

  always_ff @(posedge outclk or posedge reset) begin
    if (reset) begin
      strobe_d    <= 1'b1;
      event_count <= '0;
      settle_cnt  <= '0;
      samp_a      <= '0;
      samp_b      <= '0;
      overflow    <= 1'b0;
      mismatch    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      strobe_d <= sync_strobe;
      if (evt) event_count <= event_count + 1'b1;
      if (settle_load)          settle_cnt <= SW'(SETTLE_CYCLES);
      else if (state == SETTLE) settle_cnt <= settle_cnt - 1'b1;
      if (samp_a_en) samp_a <= async_data;
      if (samp_b_en) samp_b <= async_data;
      overflow <= overflow_set | (overflow & ~clear_flags);
      mismatch <= mismatch_set | (mismatch & ~clear_flags);
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge outclk) begin
    if (push_ok) mem[wr_ptr] <= samp_a;
  end

endmodule

// File: tb/tb_sync_word_capture.sv
// tb/tb_sync_word_capture.sv - scoreboard bench for sync_word_capture with directed capture sequences
module tb_sync_word_capture;

  logic        outclk = 1'b0;
  logic        reset = 1'b1;
  logic        sync_strobe = 1'b0;
  logic [23:0] async_data = '0;
  logic        out_ready = 1'b0;
  logic        clear_flags = 1'b0;
  logic        out_valid;
  logic [23:0] out_data;
  logic        overflow;
  logic        mismatch;
  logic [7:0]  event_count;
  logic        busy;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  base;

  sync_word_capture #(
    .DATA_W(24), .SETTLE_CYCLES(2), .FIFO_DEPTH(4), .CNT_W(8)
  ) dut (
    .outclk(outclk), .reset(reset), .sync_strobe(sync_strobe), .async_data(async_data),
    .out_ready(out_ready), .clear_flags(clear_flags), .out_valid(out_valid),
    .out_data(out_data), .overflow(overflow), .mismatch(mismatch),
    .event_count(event_count), .busy(busy)
  );

  always #5 outclk = ~outclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge outclk);
    #1;
  endtask

  // one strobe edge held two cycles; returns in cycle 6 with the FSM back in IDLE
  task automatic capture(input logic [23:0] d, input bit expect_push);
    if (expect_push) exp_q.push_back(d);
    async_data  = d;
    sync_strobe = 1'b1;
    tick(); tick();
    sync_strobe = 1'b0;
    repeat (4) tick();
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
  endtask

  always @(negedge outclk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got %0h expected none", out_data);
      end else begin
        check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_mismatch", 32'(mismatch), 0);
    check("rst_count", 32'(event_count), 0);
    check("rst_busy", 32'(busy), 0);

    // 1: basic capture, latency to cycle 6
    exp_q.push_back(24'h0A1B2C);
    async_data  = 24'h0A1B2C;
    sync_strobe = 1'b1;
    tick();
    check("t1_busy", 32'(busy), 1);
    tick();
    sync_strobe = 1'b0;
    repeat (3) tick();
    check("t1_valid_c5", 32'(out_valid), 0);
    tick();
    check("t1_valid_c6", 32'(out_valid), 1);
    check("t1_data", 32'(out_data), 32'h0A1B2C);
    check("t1_count", 32'(event_count), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_empty", 32'(out_valid), 0);

    // 2: data changes between the two samples
    async_data  = 24'h000001;
    sync_strobe = 1'b1;
    tick(); tick();
    sync_strobe = 1'b0;
    tick(); tick();
    async_data = 24'h000002;
    tick(); tick();
    check("t2_mismatch", 32'(mismatch), 1);
    check("t2_valid", 32'(out_valid), 0);
    check("t2_overflow", 32'(overflow), 0);
    pulse_clear();
    check("t2_clear", 32'(mismatch), 0);

    // 3: five words into a depth-4 FIFO, then drain
    for (int i = 1; i <= 5; i++) capture(24'h100000 + 24'(i), i <= 4);
    check("t3_overflow", 32'(overflow), 1);
    check("t3_head", 32'(out_data), 32'h100001);
    out_ready = 1'b1;
    repeat (6) tick();
    out_ready = 1'b0;
    check("t3_drained", 32'(out_valid), 0);
    check("t3_zero_data", 32'(out_data), 0);
    check("t3_q_empty", exp_q.size(), 0);
    pulse_clear();
    check("t3_clear", 32'(overflow), 0);

    // 4: second edge during SETTLE
    base      = event_count;
    out_ready = 1'b1;
    exp_q.push_back(24'hABCDEF);
    async_data  = 24'hABCDEF;
    sync_strobe = 1'b1;
    tick();
    sync_strobe = 1'b0;
    tick();
    sync_strobe = 1'b1;
    tick();
    sync_strobe = 1'b0;
    check("t4_overflow", 32'(overflow), 1);
    check("t4_count", 32'(event_count), 32'(8'(base + 8'd2)));
    repeat (6) tick();
    check("t4_q_empty", exp_q.size(), 0);
    check("t4_idle", 32'(busy), 0);
    out_ready = 1'b0;
    pulse_clear();

    // 5: full FIFO, push and pop in the same cycle
    for (int i = 1; i <= 4; i++) capture(24'h200000 + 24'(i), 1);
    exp_q.push_back(24'h200005);
    async_data  = 24'h200005;
    sync_strobe = 1'b1;
    tick(); tick();
    sync_strobe = 1'b0;
    tick(); tick(); tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_overflow", 32'(overflow), 0);
    check("t5_head", 32'(out_data), 32'h200002);
    capture(24'h200006, 0);
    check("t5_full_drop", 32'(overflow), 1);
    pulse_clear();
    check("t5_clear_ovf", 32'(overflow), 0);
    check("t5_clear_mm", 32'(mismatch), 0);
    out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0;
    check("t5_q_empty", exp_q.size(), 0);
    check("t5_drained", 32'(out_valid), 0);

    // 6: reset during SAMPLE_B with two words queued, strobe held high through release
    capture(24'h300001, 0);
    capture(24'h300002, 0);
    check("t6_queued", 32'(out_valid), 1);
    async_data  = 24'h777777;
    sync_strobe = 1'b1;
    repeat (4) tick();
    check("t6_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_data", 32'(out_data), 0);
    check("t6_rst_count", 32'(event_count), 0);
    check("t6_rst_busy", 32'(busy), 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("t6_no_event", 32'(event_count), 0);
    check("t6_no_busy", 32'(busy), 0);
    check("t6_no_valid", 32'(out_valid), 0);
    sync_strobe = 1'b0;
    tick();
    capture(24'h777777, 1);
    check("t6_event", 32'(event_count), 1);
    check("t6_valid", 32'(out_valid), 1);
    check("t6_data", 32'(out_data), 32'h777777);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("final_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
